// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control for a short in-order pipeline. Tracks PIPE_DEPTH slots
// (EX = slot 0 .. WB = slot PIPE_DEPTH-1). Decodes EX, resolves forwarding,
// applies a one-cycle load-use stall and squashes fetch slots after a taken transfer.
module pipe_ctrl #(
  parameter int unsigned PIPE_DEPTH   = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   inst_i,
  input  logic                          inst_valid_i,
  output logic                          inst_ready_o,
  input  logic                          br_eq_i,
  input  logic                          br_lt_i,
  output logic                          br_un_o,
  output logic [$clog2(PIPE_DEPTH)-1:0] fwd_a_sel_o,
  output logic [$clog2(PIPE_DEPTH)-1:0] fwd_b_sel_o,
  output logic                          a_pc_sel_o,
  output logic                          b_imm_sel_o,
  output logic [3:0]                    alu_op_o,
  output logic                          mem_we_o,
  output logic                          mem_re_o,
  output logic [1:0]                    wb_sel_o,
  output logic                          reg_w_en_o,
  output logic [4:0]                    reg_w_addr_o,
  output logic                          pc_sel_o,
  output logic                          flush_o,
  output logic [CNT_W-1:0]              stall_cnt_o,
  output logic [CNT_W-1:0]              flush_cnt_o
);
  localparam int unsigned SelW = $clog2(PIPE_DEPTH);
  localparam int unsigned Wb   = PIPE_DEPTH - 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRegImm = 7'b0010011;
  localparam logic [6:0] OpRegReg = 7'b0110011;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  localparam logic [3:0] AluNop  = 4'd0;
  localparam logic [3:0] AluAdd  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluSll  = 4'd3;
  localparam logic [3:0] AluSrl  = 4'd4;
  localparam logic [3:0] AluOr   = 4'd5;
  localparam logic [3:0] AluXor  = 4'd6;
  localparam logic [3:0] AluOne  = 4'd7;
  localparam logic [3:0] AluZero = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;
  localparam logic [3:0] AluLui  = 4'd10;
  localparam logic [3:0] AluSub  = 4'd11;

  logic [31:0]           inst_q [PIPE_DEPTH];
  logic [31:0]           inst_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [1:0]            flush_q, flush_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [PIPE_DEPTH-1:0] live, writes_rd;
  logic [6:0]            op0, op1, opw, f7_0;
  logic [4:0]            rs1_0, rs2_0, rd1;
  logic [2:0]            f3_0;
  logic [3:0]            slt_res;
  logic                  use_rs1, use_rs2, stall, taken, take, flush_open;

  assign op0   = inst_q[0][6:0];
  assign rs1_0 = inst_q[0][19:15];
  assign rs2_0 = inst_q[0][24:20];
  assign f3_0  = inst_q[0][14:12];
  assign f7_0  = inst_q[0][31:25];
  assign op1   = inst_q[1][6:0];
  assign rd1   = inst_q[1][11:7];
  assign opw   = inst_q[Wb][6:0];

  // Per-slot liveness (valid and not the all-zero opcode) and rd-write qualification
  always_comb begin
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      live[k]      = valid_q[k] && (inst_q[k][6:0] != 7'd0);
      writes_rd[k] = live[k] && (inst_q[k][6:0] != OpStore) && (inst_q[k][6:0] != OpBranch)
                     && (inst_q[k][11:7] != 5'd0);
    end
  end

  assign use_rs1 = live[0] && (op0 != OpLui) && (op0 != OpAuipc) && (op0 != OpJal);
  assign use_rs2 = live[0] && ((op0 == OpRegReg) || (op0 == OpStore) || (op0 == OpBranch));

  // Forward from the youngest producing slot; scanning oldest-first lets younger ones win
  always_comb begin
    fwd_a_sel_o = '0;
    fwd_b_sel_o = '0;
    for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
      if (use_rs1 && writes_rd[k] && (inst_q[k][11:7] == rs1_0)) fwd_a_sel_o = SelW'(k);
      if (use_rs2 && writes_rd[k] && (inst_q[k][11:7] == rs2_0)) fwd_b_sel_o = SelW'(k);
    end
  end

  assign stall = live[1] && (op1 == OpLoad) && writes_rd[1] &&
                 ((use_rs1 && (rd1 == rs1_0)) || (use_rs2 && (rd1 == rs2_0)));

  assign slt_res = (br_lt_i && !br_eq_i) ? AluOne : AluZero;

  // EX decode: ALU op, operand selects, comparator mode and transfer resolution
  always_comb begin
    alu_op_o    = AluNop;
    br_un_o     = 1'b0;
    a_pc_sel_o  = 1'b0;
    b_imm_sel_o = 1'b0;
    taken       = 1'b0;
    if (live[0]) begin
      b_imm_sel_o = (op0 != OpRegReg);
      case (op0)
        OpRegReg, OpRegImm: begin
          unique case (f3_0)
            3'b000: alu_op_o = ((op0 == OpRegReg) && (f7_0 == F7Alt)) ? AluSub : AluAdd;
            3'b001: alu_op_o = AluSll;
            3'b010: alu_op_o = slt_res;
            3'b011: begin
              alu_op_o = slt_res;
              br_un_o  = 1'b1;
            end
            3'b100: alu_op_o = AluXor;
            3'b101: alu_op_o = (f7_0 == F7Alt) ? AluSra : AluSrl;
            3'b110: alu_op_o = AluOr;
            3'b111: alu_op_o = AluAnd;
          endcase
        end
        OpLoad, OpStore: alu_op_o = AluAdd;
        OpJal, OpJalr: begin
          alu_op_o   = AluAdd;
          a_pc_sel_o = 1'b1;
          taken      = 1'b1;
        end
        OpAuipc: begin
          alu_op_o   = AluAdd;
          a_pc_sel_o = 1'b1;
        end
        OpLui: alu_op_o = AluLui;
        OpBranch: begin
          alu_op_o   = AluAdd;
          a_pc_sel_o = 1'b1;
          br_un_o    = (f3_0[2:1] == 2'b11);
          case (f3_0)
            3'b000:         taken = br_eq_i;
            3'b001:         taken = !br_eq_i;
            3'b100, 3'b110: taken = br_lt_i;
            3'b101, 3'b111: taken = !br_lt_i;
            default:        taken = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign flush_open   = (flush_q != 2'd0);
  assign take         = taken && !stall;
  assign pc_sel_o     = take;
  assign flush_o      = take;
  // Held low through reset so nothing is considered accepted while rst_n is asserted
  assign inst_ready_o = rst_n && !stall;

  assign mem_we_o     = live[1] && (op1 == OpStore);
  assign mem_re_o     = live[1] && (op1 == OpLoad);
  assign reg_w_en_o   = writes_rd[Wb];
  assign reg_w_addr_o = live[Wb] ? inst_q[Wb][11:7] : 5'd0;
  assign wb_sel_o     = !live[Wb]                               ? 2'd0 :
                        (opw == OpLoad)                         ? 2'd1 :
                        ((opw == OpJal) || (opw == OpJalr))     ? 2'd2 : 2'd0;

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // Slot advance: a stall freezes EX and injects a bubble behind it; the taken cycle and
  // the remaining flush window replace the fetched instruction with a bubble
  always_comb begin
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      inst_d[k]  = inst_q[k];
      valid_d[k] = valid_q[k];
    end
    for (int k = PIPE_DEPTH - 1; k >= 2; k--) begin
      inst_d[k]  = inst_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
    if (stall) begin
      valid_d[1] = 1'b0;
    end else begin
      inst_d[1]  = inst_q[0];
      valid_d[1] = valid_q[0];
      inst_d[0]  = inst_i;
      valid_d[0] = inst_valid_i && !take && !flush_open;
    end
  end

  // Flush window counts the cycles still to squash after the taken cycle itself
  always_comb begin
    flush_d = flush_q;
    if (take)                     flush_d = 2'(FLUSH_CYCLES - 1);
    else if (flush_open && !stall) flush_d = flush_q - 2'd1;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (take && (flush_cnt_q != '1))  ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '{default: '0};
      valid_q     <= '0;
      flush_q     <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus random instruction streams, every cycle compared
// against a slot-list reference model built from the instruction-set rules.
module tb_pipe_ctrl;
  localparam int D  = 4;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int SW = $clog2(D);
  localparam int CntMax = (1 << CW) - 1;

  localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpBr = 7'b1100011, OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011, OpRi = 7'b0010011, OpRr = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   inst_i = '0;
  logic          inst_valid_i = 1'b0, br_eq_i = 1'b0, br_lt_i = 1'b0;
  logic          inst_ready_o, br_un_o, a_pc_sel_o, b_imm_sel_o, mem_we_o, mem_re_o;
  logic          reg_w_en_o, pc_sel_o, flush_o;
  logic [SW-1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic [3:0]    alu_op_o;
  logic [1:0]    wb_sel_o;
  logic [4:0]    reg_w_addr_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.PIPE_DEPTH(D), .FLUSH_CYCLES(FC), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .br_eq_i(br_eq_i), .br_lt_i(br_lt_i), .br_un_o(br_un_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .a_pc_sel_o(a_pc_sel_o),
    .b_imm_sel_o(b_imm_sel_o), .alu_op_o(alu_op_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .wb_sel_o(wb_sel_o), .reg_w_en_o(reg_w_en_o),
    .reg_w_addr_o(reg_w_addr_o), .pc_sel_o(pc_sel_o), .flush_o(flush_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_inst [D];
  bit          m_v [D];
  int          m_cyc, m_drop_until, m_sc, m_fc;
  bit          m_stall_now, m_take_now;

  function automatic logic [6:0] opc(input logic [31:0] i); return i[6:0];   endfunction
  function automatic logic [4:0] rd (input logic [31:0] i); return i[11:7];  endfunction
  function automatic logic [4:0] rs1(input logic [31:0] i); return i[19:15]; endfunction
  function automatic logic [4:0] rs2(input logic [31:0] i); return i[24:20]; endfunction
  function automatic logic [2:0] f3 (input logic [31:0] i); return i[14:12]; endfunction

  function automatic bit use1(input logic [31:0] i);
    return !(opc(i) inside {OpLui, OpAuipc, OpJal});
  endfunction
  function automatic bit use2(input logic [31:0] i);
    return opc(i) inside {OpRr, OpSt, OpBr};
  endfunction
  function automatic bit writes(input logic [31:0] i);
    return !(opc(i) inside {OpSt, OpBr}) && (rd(i) != 5'd0);
  endfunction
  function automatic bit m_live(input int k);
    return m_v[k] && (opc(m_inst[k]) != 7'd0);
  endfunction
  function automatic int find_src(input logic [4:0] s);
    for (int k = 1; k < D; k++)
      if (m_live(k) && writes(m_inst[k]) && rd(m_inst[k]) == s) return k;
    return 0;
  endfunction

  // ALU op from the mnemonic table for the register/immediate groups
  function automatic int exp_alu(input logic [31:0] i, input bit eq, input bit lt);
    int tbl [8] = '{1, 3, 0, 0, 6, 4, 5, 2};
    int r;
    case (opc(i))
      OpRr, OpRi: begin
        r = tbl[f3(i)];
        if (f3(i) == 3'd2 || f3(i) == 3'd3) r = (lt && !eq) ? 7 : 8;
        if (f3(i) == 3'd0 && opc(i) == OpRr && i[31:25] == 7'h20) r = 11;
        if (f3(i) == 3'd5 && i[31:25] == 7'h20) r = 9;
        return r;
      end
      OpLd, OpSt, OpBr, OpJal, OpJalr, OpAuipc: return 1;
      OpLui: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_taken(input logic [31:0] i, input bit eq, input bit lt);
    bit cond;
    if (opc(i) == OpJal || opc(i) == OpJalr) return 1'b1;
    if (opc(i) != OpBr || f3(i) == 3'd2 || f3(i) == 3'd3) return 1'b0;
    cond = f3(i)[2] ? lt : eq;
    return f3(i)[0] ? !cond : cond;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < D; k++) begin m_v[k] = 1'b0; m_inst[k] = '0; end
    m_drop_until = 0; m_sc = 0; m_fc = 0; m_cyc = 0;
  endtask

  task automatic compare_all();
    logic [31:0] i0, i1, iw;
    bit l0, lw;
    int fa, fb, ws;
    i0 = m_inst[0]; i1 = m_inst[1]; iw = m_inst[D-1];
    l0 = m_live(0); lw = m_live(D-1);
    m_stall_now = l0 && m_live(1) && opc(i1) == OpLd && writes(i1) &&
                  ((use1(i0) && rd(i1) == rs1(i0)) || (use2(i0) && rd(i1) == rs2(i0)));
    m_take_now = l0 && !m_stall_now && exp_taken(i0, br_eq_i, br_lt_i);
    fa = (l0 && use1(i0)) ? find_src(rs1(i0)) : 0;
    fb = (l0 && use2(i0)) ? find_src(rs2(i0)) : 0;
    ws = !lw ? 0 : (opc(iw) == OpLd) ? 1 : (opc(iw) inside {OpJal, OpJalr}) ? 2 : 0;
    chk("inst_ready", inst_ready_o, !m_stall_now);
    chk("fwd_a", fwd_a_sel_o, fa);
    chk("fwd_b", fwd_b_sel_o, fb);
    chk("alu_op", alu_op_o, l0 ? exp_alu(i0, br_eq_i, br_lt_i) : 0);
    chk("br_un", br_un_o, l0 && ((opc(i0) inside {OpRr, OpRi} && f3(i0) == 3'd3) ||
                                 (opc(i0) == OpBr && f3(i0) inside {3'd6, 3'd7})));
    chk("a_pc_sel", a_pc_sel_o, l0 && (opc(i0) inside {OpBr, OpJal, OpJalr, OpAuipc}));
    chk("b_imm_sel", b_imm_sel_o, l0 && opc(i0) != OpRr);
    chk("mem_we", mem_we_o, m_live(1) && opc(i1) == OpSt);
    chk("mem_re", mem_re_o, m_live(1) && opc(i1) == OpLd);
    chk("reg_w_en", reg_w_en_o, lw && writes(iw));
    chk("reg_w_addr", reg_w_addr_o, lw ? rd(iw) : 5'd0);
    chk("wb_sel", wb_sel_o, ws);
    chk("pc_sel", pc_sel_o, m_take_now);
    chk("flush", flush_o, m_take_now);
    chk("stall_cnt", stall_cnt_o, m_sc);
    chk("flush_cnt", flush_cnt_o, m_fc);
  endtask

  task automatic eval();
    @(negedge clk);
    compare_all();
  endtask

  // Model clock edge, then move the bench to just after the DUT edge
  task automatic adv();
    bit drop;
    drop = m_take_now || (m_cyc < m_drop_until);
    if (m_take_now) m_drop_until = m_cyc + FC;
    if (m_stall_now && m_sc < CntMax) m_sc++;
    if (m_take_now && m_fc < CntMax) m_fc++;
    for (int k = D - 1; k >= 2; k--) begin m_inst[k] = m_inst[k-1]; m_v[k] = m_v[k-1]; end
    if (m_stall_now) begin
      m_v[1] = 1'b0;
    end else begin
      m_inst[1] = m_inst[0]; m_v[1] = m_v[0];
      m_inst[0] = inst_i;    m_v[0] = inst_valid_i && !drop;
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input bit v, input bit eq, input bit lt);
    inst_i = i; inst_valid_i = v; br_eq_i = eq; br_lt_i = lt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {inst_ready_o, br_un_o, fwd_a_sel_o, fwd_b_sel_o, a_pc_sel_o, b_imm_sel_o,
              alu_op_o, mem_we_o, mem_re_o, wb_sel_o, reg_w_en_o, reg_w_addr_o, pc_sel_o,
              flush_o}, 0);
    chk({tag, "_scnt"}, stall_cnt_o, 0);
    chk({tag, "_fcnt"}, flush_cnt_o, 0);
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_all_zero("reset_outs");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10] = '{OpRr, OpRi, OpLd, OpSt, OpBr, OpJal, OpJalr, OpLui, OpAuipc, 7'd0};
    logic [6:0] f7;
    f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq [2];
    int idx;
    m_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back RAW: both sources forwarded from slot 1
    drive(32'h003100B3, 1, 0, 0); eval(); adv();
    drive(32'h00108233, 1, 0, 0); eval(); adv();
    drive(32'h0, 0, 0, 0); eval();
    chk("raw_fwd_a", fwd_a_sel_o, 1);
    chk("raw_fwd_b", fwd_b_sel_o, 1);
    chk("raw_alu", alu_op_o, 1);
    adv();

    // Load-use: one stall cycle, then forward from slot 2
    do_reset();
    drive(32'h00032283, 1, 0, 0); eval(); adv();
    drive(32'h000283B3, 1, 0, 0); eval(); adv();
    drive(32'h0, 0, 0, 0); eval();
    chk("lu_ready", inst_ready_o, 0);
    chk("lu_mem_re", mem_re_o, 1);
    chk("lu_pc_sel", pc_sel_o, 0);
    adv(); eval();
    chk("lu_scnt", stall_cnt_o, 1);
    chk("lu_fwd_a", fwd_a_sel_o, 2);
    chk("lu_ready2", inst_ready_o, 1);
    adv();

    // Second load-use, then reset while stalled
    drive(32'h00032283, 1, 0, 0); eval(); adv();
    drive(32'h000283B3, 1, 0, 0); eval(); adv();
    drive(32'h0, 0, 0, 0); eval();
    chk("rs_stalled", inst_ready_o, 0);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rs_async");
    m_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h003100B3, 1, 0, 0);
    #1 compare_all();
    chk("rs_first_ready", inst_ready_o, 1);
    adv();
    drive(32'h0, 0, 0, 0); eval();
    chk("rs_alu", alu_op_o, 1);
    adv();

    // Taken BEQ: redirect, squash the window, branch writes nothing
    do_reset();
    drive(32'h00000463, 1, 0, 0); eval(); adv();
    drive(32'h003100B3, 1, 1, 0); eval();
    chk("beq_pc_sel", pc_sel_o, 1);
    chk("beq_flush", flush_o, 1);
    adv();
    drive(32'h00108233, 1, 0, 0); eval();
    chk("beq_drop_alu", alu_op_o, 0);
    chk("beq_fcnt", flush_cnt_o, 1);
    adv();
    drive(32'h0, 0, 0, 0); eval(); adv(); eval();
    chk("beq_wb_en", reg_w_en_o, 0);
    for (int n = 0; n < 2; n++) begin
      adv(); eval();
      chk("beq_dropped_wb", reg_w_en_o, 0);
    end
    adv();

    // JAL: taken in EX, links x1 at WB
    do_reset();
    drive(32'h008000EF, 1, 0, 0); eval(); adv();
    drive(32'h0, 0, 0, 0); eval();
    chk("jal_pc_sel", pc_sel_o, 1);
    adv();
    for (int n = 1; n < D - 1; n++) begin eval(); adv(); end
    eval();
    chk("jal_wb_en", reg_w_en_o, 1);
    chk("jal_wb_addr", reg_w_addr_o, 1);
    chk("jal_wb_sel", wb_sel_o, 2);
    adv();

    // rd = x0 never forwards and never writes
    do_reset();
    drive(32'h00100013, 1, 0, 0); eval(); adv();
    drive(32'h000000B3, 1, 0, 0); eval(); adv();
    drive(32'h0, 0, 0, 0); eval();
    chk("x0_fwd_a", fwd_a_sel_o, 0);
    chk("x0_fwd_b", fwd_b_sel_o, 0);
    adv();
    for (int n = 0; n < D - 3; n++) begin eval(); adv(); end
    eval();
    chk("x0_wb_en", reg_w_en_o, 0);
    adv(); eval();
    chk("x1_wb_en", reg_w_en_o, 1);
    adv();

    // Counter saturation: repeated JALs and load-use pairs
    do_reset();
    for (int n = 0; n < 60; n++) begin
      drive(32'h0000006F, 1, 0, 0); eval(); adv();
    end
    drive(32'h0, 0, 0, 0); eval();
    chk("fcnt_sat", flush_cnt_o, CntMax);
    adv();
    seq[0] = 32'h0000A083;
    seq[1] = 32'h00008133;
    idx = 0;
    for (int n = 0; n < 90; n++) begin
      drive(seq[idx % 2], 1, 0, 0); eval();
      if (inst_ready_o) idx++;
      adv();
    end
    drive(32'h0, 0, 0, 0); eval();
    chk("scnt_sat", stall_cnt_o, CntMax);
    adv();

    // Random streams over a small register set to provoke hazards
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive(rand_inst(), $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
      eval();
      adv();
      if (n == 300) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 3, number of tracked stages (EX=slot0 .. WB=slot PIPE_DEPTH-1), legal 3..6.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, number of fetch slots discarded after a taken control transfer, legal 1..2.
REQ-003 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port inst_i, input, 32, instruction offered to EX.
REQ-008 SHALL have port inst_valid_i, input, 1, inst_i valid.
REQ-009 SHALL have port inst_ready_o, output, 1, instruction accepted this cycle.
REQ-010 SHALL have ports br_eq_i and br_lt_i, input, 1 each, branch comparator results for the slot0 operands.
REQ-011 SHALL have port br_un_o, output, 1, unsigned comparison request.
REQ-012 SHALL have ports fwd_a_sel_o and fwd_b_sel_o, output, $clog2(PIPE_DEPTH) each: 0 selects the register file; k selects the slot-k result.
REQ-013 SHALL have ports a_pc_sel_o and b_imm_sel_o, output, 1 each, ALU operand A from PC and operand B from the immediate.
REQ-014 SHALL have port alu_op_o, output, 4. Encoding: 0 NOP, 1 ADD, 2 AND, 3 SLL, 4 SRL, 5 OR, 6 XOR, 7 ONE, 8 ZERO, 9 SRA, 10 LUI, 11 SUB.
REQ-015 SHALL have ports mem_we_o and mem_re_o, output, 1 each, slot1 store and slot1 load strobes.
REQ-016 SHALL have port wb_sel_o, output, 2: 0 ALU, 1 memory, 2 PC+4.
REQ-017 SHALL have ports reg_w_en_o (output, 1) and reg_w_addr_o (output, 5), WB write enable and write address.
REQ-018 SHALL have ports pc_sel_o and flush_o, output, 1 each, redirect to target and squash wrong path.
REQ-019 SHALL have ports stall_cnt_o and flush_cnt_o, output, CNT_W each.

Function
REQ-020 Each slot SHALL hold {inst[31:0], valid}. A slot with valid=0 or opcode 0000000 is a bubble that produces NOP/0 controls.
REQ-021 When not stalling, each clock SHALL shift slot k into slot k+1; slot0 loads inst_i when inst_valid_i && inst_ready_o && flush window closed, and loads a bubble otherwise.
REQ-022 rs1 SHALL count as used for all opcodes except LUI, AUIPC and JAL; rs2 SHALL count as used only for REGREG, STORE and BRANCH.
REQ-023 An instruction SHALL count as writing rd unless it is STORE or BRANCH; rd=x0 SHALL never match and SHALL never be written.
REQ-024 fwd_X_sel_o SHALL be the smallest k in 1..PIPE_DEPTH-1 whose valid slot writes an rd equal to the used source; otherwise it is 0.
REQ-025 Load-use: if slot1 is a valid LOAD whose rd matches a used source of slot0, the block SHALL stall for exactly 1 cycle.
REQ-026 During a stall: inst_ready_o=0, slot0 holds, slot1 receives a bubble, slots 2+ shift normally, and pc_sel_o/flush_o are forced to 0.
REQ-027 Operand selects: a_pc_sel_o=1 for BRANCH, JAL, JALR and AUIPC; b_imm_sel_o=1 for every non-bubble opcode except REGREG.
REQ-028 ALU op: REGREG/REGIMM per funct3/funct7 (funct7 0100000 selects SUB/SRA). LOAD, STORE, BRANCH, JAL, JALR and AUIPC use ADD; LUI uses LUI.
REQ-029 SLT/SLTI SHALL produce ONE if br_lt_i && !br_eq_i, else ZERO. br_un_o=1 for SLTU, SLTIU, BLTU and BGEU.
REQ-030 Taken conditions: BEQ eq; BNE !eq; BLT/BLTU lt; BGE/BGEU !lt. JAL and JALR are always taken.
REQ-031 A taken slot0 transfer that is not stalled SHALL assert pc_sel_o and flush_o combinationally in the same cycle, then force bubbles into slot0 for the next FLUSH_CYCLES cycles.
REQ-032 The flush window SHALL have priority over inst_valid_i; instructions offered in the window are dropped, with inst_ready_o=1.
REQ-033 A stall and a taken branch in the same cycle: the stall SHALL win, and the branch is re-evaluated the following cycle.
REQ-034 mem_we_o/mem_re_o SHALL reflect a valid STORE/LOAD in slot1.
REQ-035 WB slot: reg_w_en_o per REQ-023, reg_w_addr_o=rd. wb_sel_o is 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
REQ-036 stall_cnt_o SHALL increment per stall cycle and flush_cnt_o per pc_sel_o cycle; both saturate at all-ones.

Reset
REQ-037 rst_n low SHALL immediately clear all slot valids, the flush window and both counters; every output is 0, including inst_ready_o.
REQ-038 The first rising clk edge after rst_n rises SHALL accept inst_i normally. Reset mid-stall or mid-flush SHALL abandon it.

Verification
REQ-039 0x003100B3 then 0x00108233 -> second instruction in slot0: fwd_a_sel_o=1, fwd_b_sel_o=1, alu_op_o=1.
REQ-040 0x00032283 then 0x000283B3 -> one cycle inst_ready_o=0, stall_cnt_o=1; next cycle fwd_a_sel_o=2, mem_re_o reflects the load in slot1.
REQ-041 0x00000463 with br_eq_i=1 -> pc_sel_o=1, flush_o=1; the next valid inst_i is dropped; flush_cnt_o=1; at WB reg_w_en_o=0.
REQ-042 0x008000EF -> pc_sel_o=1 in EX; PIPE_DEPTH-1 cycles later reg_w_en_o=1, reg_w_addr_o=1, wb_sel_o=2.
REQ-043 0x00100013 then 0x000000B3 -> fwd selects 0; the first instruction at WB gives reg_w_en_o=0.
REQ-044 rst_n pulsed low during a load-use stall -> all outputs 0 asynchronously, counters 0; after release, 0x003100B3 decodes with alu_op_o=1.
